// File: rtl/c_pgood_pkg.sv
// c_pgood_pkg: shared FSM state and fault-code encodings plus the rail voltage width
// used by the c_pgood power-good monitor.
package c_pgood_pkg;

  // Rail voltage bus width, signed, 0.01 V per LSB
  localparam int unsigned VW = 16;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RAMP  = 2'd1,
    GOOD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE = 2'd0,
    FC_UV   = 2'd1,
    FC_OV   = 2'd2,
    FC_TMO  = 2'd3
  } fcode_t;

endpackage

// File: rtl/c_deb.sv
// c_deb: consecutive-sample debounce counter. hit is asserted on the cycle in which
// the n-th consecutive true sample of cond is presented, so the consumer can act on
// that same edge. The count saturates at n-1 and returns to 0 on a false sample or clear.
module c_deb #(
  parameter int unsigned n = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cond,
  input  logic clear,
  output logic hit
);

  localparam int unsigned   CW  = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] TOP = CW'(n - 1);

  logic [CW-1:0] cnt;

  // hit must not depend on clear: clear is derived from the FSM next state, which uses hit
  assign hit = cond && (cnt == TOP);

  // Count consecutive true samples, saturating at n-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !cond) begin
      cnt <= '0;
    end else if (cnt != TOP) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/c_pgood.sv
// c_pgood: power-good monitor for one rail. Qualifies the rail voltage against an
// under-voltage threshold with hysteresis (plus optional over-voltage) using debounce
// counters and a rise timeout, and reports a registered pgood plus a sticky fault code.
// Optional feature: define C_PGOOD_OV_EN to build over-voltage detection (fcode 2).
module c_pgood
  import c_pgood_pkg::*;
#(
  parameter int          vth_on = 300,
  parameter int          hyst   = 10,
  parameter int          vth_ov = 360,
  parameter int unsigned tdeb   = 4,
  parameter int unsigned trise  = 2000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [VW-1:0] vin,
  input  logic          en,
  input  logic          clr,
  output logic          pgood,
  output logic          fault,
  output logic [1:0]    fcode,
  output logic [1:0]    state
);

  localparam logic signed [VW-1:0] V_ON = VW'(vth_on);
  localparam logic signed [VW-1:0] V_UV = VW'(vth_on - hyst);
  localparam int unsigned          TW   = $clog2(trise + 1);
  localparam logic [TW-1:0]        TMAX = TW'(trise - 1);

  // Elaboration-time sanity checks on the configuration
  if (tdeb < 1) begin : g_bad_tdeb
    $error("c_pgood: tdeb must be >= 1");
  end
  if (vth_ov < vth_on) begin : g_bad_ov
    $error("c_pgood: vth_ov must not be below vth_on");
  end

  state_t               st;
  state_t               nxt;
  fcode_t               fc_q;
  fcode_t               nxt_fc;
  logic [TW-1:0]        timer;
  logic signed [VW-1:0] vin_s;
  logic                 chg;
  logic                 tmo;
  logic                 rise_c, rise_hit;
  logic                 uv_c, uv_hit;
  logic                 ov_hit;

  assign vin_s  = $signed(vin);
  assign rise_c = (st == RAMP) && (vin_s >= V_ON);
  assign uv_c   = (st == GOOD) && (vin_s < V_UV);
  assign tmo    = (st == RAMP) && (timer == TMAX);
  assign chg    = (nxt != st);

  c_deb #(.n(tdeb)) u_rise (
    .clk   (clk),
    .rst   (rst),
    .cond  (rise_c),
    .clear (chg),
    .hit   (rise_hit)
  );

  c_deb #(.n(tdeb)) u_uv (
    .clk   (clk),
    .rst   (rst),
    .cond  (uv_c),
    .clear (chg),
    .hit   (uv_hit)
  );

`ifdef C_PGOOD_OV_EN
  localparam logic signed [VW-1:0] V_OV = VW'(vth_ov);

  logic ov_c;

  assign ov_c = ((st == RAMP) || (st == GOOD)) && (vin_s > V_OV);

  c_deb #(.n(tdeb)) u_ov (
    .clk   (clk),
    .rst   (rst),
    .cond  (ov_c),
    .clear (chg),
    .hit   (ov_hit)
  );
`else
  assign ov_hit = 1'b0;
`endif

  // Next state and fault code; branch order encodes event priority (en drop, OV, UV/timeout, rise)
  always_comb begin
    nxt    = st;
    nxt_fc = fc_q;
    case (st)
      OFF: begin
        if (en) nxt = RAMP;
      end
      RAMP: begin
        if (!en) begin
          nxt = OFF;
        end else if (ov_hit) begin
          nxt    = FAULT;
          nxt_fc = FC_OV;
        end else if (tmo) begin
          nxt    = FAULT;
          nxt_fc = FC_TMO;
        end else if (rise_hit) begin
          nxt = GOOD;
        end
      end
      GOOD: begin
        if (!en) begin
          nxt = OFF;
        end else if (ov_hit) begin
          nxt    = FAULT;
          nxt_fc = FC_OV;
        end else if (uv_hit) begin
          nxt    = FAULT;
          nxt_fc = FC_UV;
        end
      end
      FAULT: begin
        if (clr && !en) begin
          nxt    = OFF;
          nxt_fc = FC_NONE;
        end
      end
      default: begin
        nxt    = OFF;
        nxt_fc = FC_NONE;
      end
    endcase
  end

  // State register with outputs registered from the next-state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= OFF;
      fc_q  <= FC_NONE;
      pgood <= 1'b0;
      fault <= 1'b0;
    end else begin
      st    <= nxt;
      fc_q  <= nxt_fc;
      pgood <= (nxt == GOOD);
      fault <= (nxt == FAULT);
    end
  end

  // Rise timer: zero outside RAMP, counts edges since RAMP entry, saturates at trise-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (st != RAMP) begin
      timer <= '0;
    end else if (timer != TMAX) begin
      timer <= timer + TW'(1);
    end
  end

  assign state = st;
  assign fcode = fc_q;

endmodule

// File: tb/tb_c_pgood.sv
`timescale 1ns/1ps
module tb_c_pgood;

  localparam int VTH_ON = 300;
  localparam int HYST   = 10;
  localparam int VTH_OV = 360;
  localparam int TDEB   = 4;
  localparam int TRISE  = 2000;

  localparam int S_OFF = 0, S_RAMP = 1, S_GOOD = 2, S_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [15:0] vin;
  logic        pgood;
  logic        fault;
  logic [1:0]  fcode;
  logic [1:0]  state;

  always #5 clk = ~clk;

  c_pgood #(
    .vth_on (VTH_ON),
    .hyst   (HYST),
    .vth_ov (VTH_OV),
    .tdeb   (TDEB),
    .trise  (TRISE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .vin   (vin),
    .en    (en),
    .clr   (clr),
    .pgood (pgood),
    .fault (fault),
    .fcode (fcode),
    .state (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remembers every sample taken since entering the current state
  int         m_state = S_OFF;
  int         m_fcode = 0;
  int         m_since = 0;
  int         hist[$];
  logic [5:0] exp_q[$];
  logic [5:0] exp_w;
  logic [5:0] got_w;

  // kind 0: rise, 1: under-voltage, 2: over-voltage
  function automatic bit last_run(int kind);
    int sz;
    sz = hist.size();
    if (sz < TDEB) return 1'b0;
    for (int i = sz - TDEB; i < sz; i++) begin
      int v;
      bit ok;
      v = hist[i];
      case (kind)
        0:       ok = (v >= VTH_ON);
        1:       ok = (v < VTH_ON - HYST);
        default: ok = (v > VTH_OV);
      endcase
      if (!ok) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = S_OFF;
    m_fcode = 0;
    m_since = 0;
    hist.delete();
  endtask

  task automatic model_step(input bit e, input bit c, input int v);
    int nst;
    int nfc;
    bit ov;
    nst = m_state;
    nfc = m_fcode;
    if (m_state == S_OFF) begin
      if (e) nst = S_RAMP;
    end else if (m_state == S_FAULT) begin
      if (c && !e) begin
        nst = S_OFF;
        nfc = 0;
      end
    end else begin
      hist.push_back(v);
      m_since++;
`ifdef C_PGOOD_OV_EN
      ov = last_run(2);
`else
      ov = 1'b0;
`endif
      if (!e) begin
        nst = S_OFF;
      end else if (ov) begin
        nst = S_FAULT;
        nfc = 2;
      end else if (m_state == S_RAMP && m_since >= TRISE) begin
        nst = S_FAULT;
        nfc = 3;
      end else if (m_state == S_GOOD && last_run(1)) begin
        nst = S_FAULT;
        nfc = 1;
      end else if (m_state == S_RAMP && last_run(0)) begin
        nst = S_GOOD;
      end
    end
    if (nst != m_state) begin
      hist.delete();
      m_since = 0;
    end
    m_state = nst;
    m_fcode = nfc;
  endtask

  // Drive one sample before the edge, queue the expected post-edge outputs
  task automatic step(input bit e, input bit c, input int v);
    @(negedge clk);
    en  = e;
    clr = c;
    vin = 16'(v);
    model_step(e, c, v);
    exp_q.push_back({2'(m_state), (m_state == S_GOOD), (m_state == S_FAULT), 2'(m_fcode)});
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare registered outputs just after each edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      got_w = {state, pgood, fault, fcode};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got st=%0d pg=%0b ft=%0b fc=%0d, expected st=%0d pg=%0b ft=%0b fc=%0d",
                 $time, got_w[5:4], got_w[3], got_w[2], got_w[1:0],
                 exp_w[5:4], exp_w[3], exp_w[2], exp_w[1:0]);
      end
    end
  end

  task automatic ramp_to_good(output int rise_edges);
    int first_idx;
    int pg_idx;
    int idx;
    first_idx = -1;
    pg_idx    = -100;
    idx       = 0;
    for (int v = 0; v <= 330; v += 10) begin
      step(1'b1, 1'b0, v);
      if (first_idx < 0 && v >= VTH_ON) first_idx = idx;
      if (pg_idx < 0 && pgood === 1'b1) pg_idx = idx;
      idx++;
    end
    for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 330);
    rise_edges = pg_idx - first_idx + 1;
  endtask

  initial begin
    int re;
    int band;
    int run;
    int v;
    int bnd[6];
    bnd = '{289, 290, 299, 300, 360, 361};

    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    vin = '0;
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_pgood", int'(pgood), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_fcode", int'(fcode), 0);
    #21;
    rst = 1'b0;
    model_reset();

    // Ramp qualification
    ramp_to_good(re);
    chk("rise_latency_edges", re, 4);
    chk("ramp_state_good", int'(state), 2);
    chk("ramp_fcode", int'(fcode), 0);

    // Short UV dip does not trip, full dip does
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 280);
    chk("short_dip_pgood", int'(pgood), 1);
    for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 330);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 280);
    chk("uv_state", int'(state), 3);
    chk("uv_fcode", int'(fcode), 1);
    chk("uv_pgood", int'(pgood), 0);

    // Clear is ignored while enabled, honoured when disabled
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 280);
    chk("clr_en_ignored", int'(state), 3);
    step(1'b0, 1'b1, 280);
    chk("clr_state", int'(state), 0);
    chk("clr_fault", int'(fault), 0);
    chk("clr_fcode", int'(fcode), 0);
    step(1'b0, 1'b0, 0);

    // Requalify, then sit inside the hysteresis band
    ramp_to_good(re);
    chk("requal_rise_edges", re, 4);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 295);
    chk("hyst_band_state", int'(state), 2);

    // Over-voltage
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 370);
`ifdef C_PGOOD_OV_EN
    chk("ov_fcode", int'(fcode), 2);
    chk("ov_state", int'(state), 3);
`else
    chk("ov_off_state", int'(state), 2);
    chk("ov_off_pgood", int'(pgood), 1);
`endif
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);

    // Rise timeout
    step(1'b1, 1'b0, 200);
    for (int k = 1; k < TRISE; k++) step(1'b1, 1'b0, 200);
    chk("tmo_pre_state", int'(state), 1);
    step(1'b1, 1'b0, 200);
    chk("tmo_fault", int'(fault), 1);
    chk("tmo_fcode", int'(fcode), 3);
    step(1'b0, 1'b1, 200);
    step(1'b0, 1'b0, 0);

    // en drop one edge before the timeout
    step(1'b1, 1'b0, 200);
    for (int k = 1; k < TRISE - 1; k++) step(1'b1, 1'b0, 200);
    step(1'b0, 1'b0, 200);
    chk("tmo_abort_state", int'(state), 0);
    chk("tmo_abort_fault", int'(fault), 0);
    step(1'b0, 1'b0, 0);

    // Asynchronous reset while GOOD
    ramp_to_good(re);
    rst = 1'b1;
    #1;
    chk("async_rst_pgood", int'(pgood), 0);
    chk("async_rst_state", int'(state), 0);
    #1;
    rst = 1'b0;
    model_reset();

    // en drop coinciding with the UV debounce hit
    ramp_to_good(re);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 280);
    step(1'b0, 1'b0, 280);
    chk("en_vs_uv_state", int'(state), 0);
    chk("en_vs_uv_fcode", int'(fcode), 0);

    // Randomised runs of voltage bands with occasional en drops and clears
    band = 1;
    run  = 0;
    for (int i = 0; i < 6000; i++) begin
      bit e;
      bit c;
      if (run == 0) begin
        band = int'($urandom_range(0, 5));
        run  = int'($urandom_range(1, 8));
      end
      run--;
      case (band)
        0:       v = -int'($urandom_range(1, 500));
        1:       v = int'($urandom_range(0, 289));
        2:       v = int'($urandom_range(290, 299));
        3:       v = int'($urandom_range(300, 360));
        4:       v = int'($urandom_range(361, 500));
        default: v = bnd[$urandom_range(0, 5)];
      endcase
      e = ($urandom_range(0, 39) != 0);
      c = ($urandom_range(0, 3) == 0);
      step(e, c, v);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
